// File: rtl/sram_req_arbiter.sv
// Two-master SRAM-like request arbiter with an in-order owner FIFO for response routing.
// Define ARB_RR_EN for round-robin arbitration in IDLE; otherwise data has fixed priority.
module sram_req_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  inst_io_cnt,
   output logic [3:0]  data_io_cnt
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {StIdle, StLockInst, StLockData} lock_state_t;

   lock_state_t state_q, state_d;
   logic grant_data;
   logic fifo_full, fifo_empty, push, pop, head_owner;
   logic inst_push, inst_pop, data_push, data_pop;
   logic [MAX_OUTSTANDING-1:0] owner_q;
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [3:0] inst_cnt_q, data_cnt_q;

`ifdef ARB_RR_EN
   logic last_grant_q;  // 1 = data was granted last

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant_q <= 1'b0;
      end else if (push) begin
         last_grant_q <= grant_data;
      end
   end
`endif

   always_comb begin
      grant_data = 1'b0;
      unique case (state_q)
         StLockInst: grant_data = 1'b0;
         StLockData: grant_data = 1'b1;
         default: begin
`ifdef ARB_RR_EN
            if (inst_req && data_req) begin
               grant_data = ~last_grant_q;
            end else begin
               grant_data = data_req;
            end
`else
            grant_data = data_req;
`endif
         end
      endcase
   end

   assign fifo_full  = (occ_q == OCC_FULL);
   assign fifo_empty = (occ_q == '0);

   // Gated by resetn so the memory side sees no request while reset is asserted.
   assign mem_req   = resetn & ~fifo_full & (grant_data ? data_req : inst_req);
   assign mem_wr    = grant_data ? data_wr    : inst_wr;
   assign mem_size  = grant_data ? data_size  : inst_size;
   assign mem_addr  = grant_data ? data_addr  : inst_addr;
   assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
   assign mem_wdata = grant_data ? data_wdata : inst_wdata;

   assign push         = mem_req & mem_addr_ok;
   assign inst_addr_ok = push & ~grant_data;
   assign data_addr_ok = push & grant_data;

   // A response with nothing outstanding is dropped: no pop, no data_ok.
   assign pop          = mem_data_ok & ~fifo_empty;
   assign head_owner   = owner_q[rd_ptr_q];
   assign inst_data_ok = pop & ~head_owner;
   assign data_data_ok = pop & head_owner;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   assign inst_push = push & ~grant_data;
   assign data_push = push & grant_data;
   assign inst_pop  = pop & ~head_owner;
   assign data_pop  = pop & head_owner;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (mem_req && !mem_addr_ok) begin
               state_d = grant_data ? StLockData : StLockInst;
            end
         end
         StLockInst, StLockData: begin
            if (mem_addr_ok) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         occ_q      <= '0;
         inst_cnt_q <= '0;
         data_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         if (push) begin
            owner_q[wr_ptr_q] <= grant_data;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (inst_push && !inst_pop) begin
            inst_cnt_q <= inst_cnt_q + 4'd1;
         end else if (!inst_push && inst_pop) begin
            inst_cnt_q <= inst_cnt_q - 4'd1;
         end
         if (data_push && !data_pop) begin
            data_cnt_q <= data_cnt_q + 4'd1;
         end else if (!data_push && data_pop) begin
            data_cnt_q <= data_cnt_q - 4'd1;
         end
      end
   end

   assign inst_io_cnt = inst_cnt_q;
   assign data_io_cnt = data_cnt_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized scoreboard bench for sram_req_arbiter against a queue-based reference model.
// Follows ARB_RR_EN the same way as the design.
module tb_sram_req_arbiter;
   localparam int unsigned MAX_OUT = 4;

   logic clk = 1'b0;
   logic resetn;
   logic inst_req, inst_wr, data_req, data_wr;
   logic [1:0] inst_size, data_size, mem_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, mem_addr, mem_wdata;
   logic [3:0] inst_wstrb, data_wstrb, mem_wstrb;
   logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata, mem_rdata;
   logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [3:0] inst_io_cnt, data_io_cnt;

   always #5 clk = ~clk;

   sram_req_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .inst_io_cnt(inst_io_cnt), .data_io_cnt(data_io_cnt)
   );

   typedef struct {
      int          owner;
      logic [31:0] data;
   } resp_t;

   int checks = 0;
   int failures = 0;
   int owner_model[$];  // owners of accepted, unanswered requests, oldest first
   resp_t exp_resp[$];
   int lock_owner = -1;
   int last_grant = 0;
   bit inst_acc = 0;
   bit data_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int count_owner(input int who);
      int n = 0;
      foreach (owner_model[i]) if (owner_model[i] == who) n++;
      return n;
   endfunction

   // Monitor: every response the DUT presents must match the oldest expected one.
   always @(negedge clk) begin
      if (resetn === 1'b1 && (inst_data_ok === 1'b1 || data_data_ok === 1'b1)) begin
         if (exp_resp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_resp: got inst=%b data=%b expected none at %0t",
                     inst_data_ok, data_data_ok, $time);
         end else begin
            resp_t r;
            r = exp_resp.pop_front();
            check("resp_owner", {30'd0, inst_data_ok, data_data_ok}, (r.owner == 0) ? 2 : 1);
            check("resp_rdata", (r.owner == 0) ? inst_rdata : data_rdata, r.data);
         end
      end
   end

   task automatic new_reqs(input int p_inst, input int p_data);
      if (inst_acc) inst_req = 1'b0;
      if (data_acc) data_req = 1'b0;
      inst_acc = 0;
      data_acc = 0;
      if (!inst_req && $urandom_range(99) < p_inst) begin
         inst_req   = 1'b1;
         inst_wr    = 1'b0;
         inst_size  = 2'($urandom);
         inst_addr  = $urandom;
         inst_wstrb = 4'($urandom);
         inst_wdata = $urandom;
      end
      if (!data_req && $urandom_range(99) < p_data) begin
         data_req   = 1'b1;
         data_wr    = 1'($urandom);
         data_size  = 2'($urandom);
         data_addr  = $urandom;
         data_wstrb = 4'($urandom);
         data_wdata = $urandom;
      end
   endtask

   task automatic step(input int p_inst, input int p_data, input int p_aok, input int p_dok);
      int g;
      bit exp_req, acc;
      int pop_owner;
      @(posedge clk);
      #1;
      new_reqs(p_inst, p_data);
      mem_addr_ok = ($urandom_range(99) < p_aok);
      mem_data_ok = ($urandom_range(99) < p_dok);
      mem_rdata   = $urandom;
      #1;
      if (lock_owner >= 0) g = lock_owner;
`ifdef ARB_RR_EN
      else if (inst_req && data_req) g = (last_grant == 0) ? 1 : 0;
`else
      else if (inst_req && data_req) g = 1;
`endif
      else if (data_req) g = 1;
      else if (inst_req) g = 0;
      else g = -1;
      exp_req = (g >= 0) && ((g == 0) ? inst_req : data_req) && (owner_model.size() < MAX_OUT);
      acc = exp_req && mem_addr_ok;

      check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      if (exp_req) begin
         check("mem_addr", mem_addr, (g == 0) ? inst_addr : data_addr);
         check("mem_wdata", mem_wdata, (g == 0) ? inst_wdata : data_wdata);
         check("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
               (g == 0) ? {25'd0, inst_wr, inst_size, inst_wstrb}
                        : {25'd0, data_wr, data_size, data_wstrb});
      end
      check("addr_ok", {30'd0, inst_addr_ok, data_addr_ok},
            {30'd0, acc && g == 0, acc && g == 1});
      check("inst_io_cnt", {28'd0, inst_io_cnt}, count_owner(0));
      check("data_io_cnt", {28'd0, data_io_cnt}, count_owner(1));

      pop_owner = -1;
      if (mem_data_ok && owner_model.size() > 0) begin
         pop_owner = owner_model.pop_front();
         exp_resp.push_back('{pop_owner, mem_rdata});
      end
      check("data_ok", {30'd0, inst_data_ok, data_data_ok},
            {30'd0, pop_owner == 0, pop_owner == 1});

      if (acc) begin
         owner_model.push_back(g);
         last_grant = g;
         lock_owner = -1;
         if (g == 0) inst_acc = 1;
         else data_acc = 1;
      end else if (exp_req && lock_owner < 0) begin
         lock_owner = g;
      end
   endtask

   task automatic run(input int n, input int pi, input int pd, input int pa, input int po);
      for (int i = 0; i < n; i++) step(pi, pd, pa, po);
   endtask

   initial begin
      resetn = 1'b0;
      inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1C00_0000;
      inst_wstrb = 4'hF; inst_wdata = '0;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1C01_0000;
      data_wstrb = 4'hF; data_wdata = '0;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
      #3;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      check("rst_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'd0);
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;

      run(300, 60, 60, 90, 10);   // backpressure: FIFO fills often
      run(300, 50, 50, 60, 50);
      run(300, 70, 70, 30, 40);   // slow accept: long locks

      // Async reset with requests outstanding
      run(1, 100, 100, 100, 0);
      run(1, 100, 100, 100, 0);
      #1;
      inst_req = 1'b1; data_req = 1'b1;
      resetn = 1'b0;
      #1;
      check("arst_mem_req", {31'd0, mem_req}, 32'd0);
      check("arst_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'd0);
      check("arst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      owner_model.delete();
      exp_resp.delete();
      lock_owner = -1; last_grant = 0; inst_acc = 0; data_acc = 0;
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;

      run(3, 0, 0, 0, 100);       // spurious responses with nothing outstanding
      run(300, 50, 50, 70, 50);
      run(40, 0, 0, 0, 100);      // drain
      @(negedge clk);
      check("drain_resp_q", exp_resp.size(), 32'd0);
      check("drain_owner_q", owner_model.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between two SRAM-like masters: instruction fetch (preIF/IF) and data access (EXE/MEM).
- Forwards one request per accepted handshake.
- Records the owner of each accepted request in an in-order owner FIFO, and routes every returned data_ok/rdata to that owner.
- Sits between the CPU core and the AXI bridge. Also reports per-master outstanding counts, which IF uses for its cancel logic.

Parameters:
- MAX_OUTSTANDING, 4: depth of the owner FIFO, i.e. the maximum number of accepted but not yet answered requests. Power of two, 2..8.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  instruction master request.
- inst_wr  in  1  write flag; always 0 for fetch but carried through.
- inst_size  in  2  transfer size.
- inst_addr  in  32  address.
- inst_wstrb  in  4  byte strobes.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  instruction request accepted.
- inst_data_ok  out  1  instruction response valid.
- inst_rdata  out  32  instruction response data.
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data master request; same meaning as the inst_* inputs.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  data response valid.
- data_rdata  out  32  data response data.
- mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/1/2/32/4/32  request to the memory side.
- mem_addr_ok  in  1  memory side accepted the request.
- mem_data_ok  in  1  memory side response valid.
- mem_rdata  in  32  memory side response data.
- inst_io_cnt  out  4  outstanding instruction requests.
- data_io_cnt  out  4  outstanding data requests.

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous, active-low.
- Reset values:
  - owner FIFO empty; lock state IDLE.
  - inst_io_cnt = data_io_cnt = 0.
  - all *_addr_ok and *_data_ok = 0; mem_req = 0.
- Lock state machine, states IDLE / LOCK_INST / LOCK_DATA:
  - IDLE: grant chosen combinationally. data wins over inst when both request.
  - IDLE → LOCK_x when mem_req=1, mem_addr_ok=0 and grant=x.
  - LOCK_x: grant is forced to x; mem_* fields come from x. The SRAM-like protocol requires req to hold until addr_ok.
  - LOCK_x → IDLE when mem_addr_ok=1.
- mem_req = (granted master's req) & !fifo_full. While the FIFO is full: mem_req=0 and both *_addr_ok=0.
- Request handshake:
  - granted master's addr_ok = mem_addr_ok & mem_req.
  - non-granted master's addr_ok = 0.
  - Zero added latency on the request path (combinational pass-through).
- Owner FIFO:
  - push the owner bit (0=inst, 1=data) on mem_req & mem_addr_ok.
  - pop on mem_data_ok.
- Response routing:
  - inst_data_ok = mem_data_ok & head==0; data_data_ok = mem_data_ok & head==1.
  - Both rdata outputs = mem_rdata unconditionally.
  - Zero added latency on the response path.
- Simultaneous push and pop in one cycle: occupancy unchanged; head advances and the tail is written. A push while full is impossible because mem_req is gated.
- Pointer wrap: pointers wrap modulo MAX_OUTSTANDING. Full/empty is decided by an occupancy counter of width log2(MAX_OUTSTANDING)+1.
- Outstanding counters:
  - inst_io_cnt: +1 on inst push, -1 on inst pop, unchanged when both happen in the same cycle. data_io_cnt follows the same rule.
  - Sum of the two counters always equals FIFO occupancy.
- Illegal condition: mem_data_ok while the FIFO is empty. Both data_ok outputs are 0, there is no pop, and counters are unchanged.
- Reset mid-transaction clears all state immediately. In-flight responses are not tracked after reset.
- A master may drop req before addr_ok only while not locked. Once locked, it must hold req stable; this is a master obligation, and the arbiter holds the lock regardless.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration in IDLE. A last_grant register (reset value inst) gives the next contested grant to the master not granted last. last_grant updates on every accepted request.
- Not defined: fixed priority, data over inst. No last_grant register.

Test Plan:
- Reset, then single fetch: inst_req=1 addr 0x1C000000, mem_addr_ok=1 in the same cycle → inst_addr_ok=1, inst_io_cnt=1. Then mem_data_ok=1 with rdata 0x02800C0C → inst_data_ok=1, inst_rdata=0x02800C0C, inst_io_cnt=0.
- Contention with fixed priority: inst_req=data_req=1, data_addr 0x1C010000 → mem_addr=0x1C010000, data_addr_ok=1, inst_addr_ok=0. Next cycle the inst request is forwarded.
- Lock hold: inst granted with mem_addr_ok=0 for 3 cycles; data_req rises in cycle 2 → mem_addr stays at the inst address and inst wins when addr_ok arrives. The data request is forwarded only after that.
- Backpressure: accept 4 requests (MAX_OUTSTANDING=4) with no data_ok → mem_req=0 and both addr_ok=0 despite pending reqs. One mem_data_ok → the next request is accepted the following cycle.
- Ordering: accept inst, data, inst; return 3 responses 0xA, 0xB, 0xC → inst_data_ok gets 0xA, data_data_ok gets 0xB, inst_data_ok gets 0xC. Counters go to 0.
- Async reset with 2 requests outstanding → counters and mem_req are 0 without any clock edge. A spurious mem_data_ok afterwards produces no data_ok.
